// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the datapath memory responder.
//   state_e      - responder FSM encoding
//   *_DEF        - default data/address widths
//   CNT_W        - width of the wait-state counter (WAIT_STATES up to 15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: 2**DEPTH_LOG2 x DATA_WIDTH word storage, single address port.
//   clk    - rising-edge clock
//   we     - write enable, wdata stored at addr on the edge
//   re     - read enable, mem[addr] registered into rdata on the edge
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data (holds until the next read)
// Contents and rdata are deliberately not reset.
module mem_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the multicycle datapath memory interface.
// Accepts one request at a time, waits WAIT_STATES cycles, performs the
// access on mem_word_array and presents a response via valid/ready.
//   clk, reset            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 = write, 0 = read
//   req_addr, req_wdata   - byte address, write data
//   resp_valid/resp_ready - response handshake
//   resp_rdata            - read data (0 for writes and errors)
//   resp_err              - misaligned or out-of-range access
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic                  rd_sel_q;    // response carries array read data

    logic                  addr_err;
    logic                  arr_we;
    logic                  arr_re;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Decode works on the captured copy so req_* may change after accept.
    assign addr_err = (cap_addr[1:0] != 2'b00) ||
                      (cap_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    assign arr_idx  = cap_addr[DEPTH_LOG2+1:2];
    assign arr_we   = (state == ACCESS) &&  cap_write && !addr_err;
    assign arr_re   = (state == ACCESS) && !cap_write && !addr_err;

    mem_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_idx),
        .wdata (cap_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready comes up one edge after reset release.
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        cap_write   <= req_write;
                        cap_addr    <= req_addr;
                        cap_wdata   <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= ACCESS;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ACCESS: begin
                    // Array read lands in arr_rdata on this same edge.
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= addr_err;
                    rd_sel_q     <= arr_re;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        rd_sel_q     <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    // arr_rdata is not reset; gate so writes, errors and reset show zero.
    assign resp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    // DUT with WAIT_STATES = 2
    logic        req_valid, req_write, resp_ready;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    // DUT with WAIT_STATES = 0
    logic        z_req_valid, z_req_write, z_resp_ready;
    logic [15:0] z_req_addr;
    logic [31:0] z_req_wdata;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .req_ready(z_req_ready),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic do_req(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          output bit ok);
        ok = 1'b0;
        req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    // Count edges from accept until resp_valid is seen; -1 on timeout.
    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (resp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b rdata=%h err=%b, want 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready, z_req_ready);
        end
    endtask

    task automatic test_write_read();
        bit ok; int cyc;
        // background words used by later error/reset tests
        do_req(1'b1, 16'h0000, 32'h1111_1111, ok); wait_resp(cyc); finish_resp();
        do_req(1'b1, 16'h0020, 32'hA5A5_A5A5, ok); wait_resp(cyc); finish_resp();

        do_req(1'b1, 16'h0010, 32'hDEAD_BEEF, ok);
        wait_resp(cyc);
        checks++;
        if (!ok || cyc !== 3 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_ack: ok=%0d lat=%0d err=%b rdata=%h, want 1 3 0 0",
                     ok, cyc, resp_err, resp_rdata);
        end
        finish_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_done_idle: rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        end

        do_req(1'b0, 16'h0010, 32'h0, ok);
        wait_resp(cyc);
        checks++;
        if (!ok || cyc !== 3 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_after_write: ok=%0d lat=%0d rdata=%h err=%b, want 1 3 deadbeef 0",
                     ok, cyc, resp_rdata, resp_err);
        end
        finish_resp();
    endtask

    task automatic test_zero_wait();
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            z_req_write = (pass == 0); z_req_addr = 16'h0004; z_req_wdata = 32'h0BAD_F00D;
            z_req_valid = 1'b1;
            checks++;
            if (z_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL zw_ready pass%0d: got %b want 1", pass, z_req_ready);
            end
            tick();                 // accepting edge
            z_req_valid = 1'b0;
            checks++;
            if (z_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL zw_early_valid pass%0d: got %b want 0", pass, z_resp_valid);
            end
            cyc = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (z_resp_valid) begin cyc = i; break; end
            end
            checks++;
            if (cyc !== 1 || z_resp_err !== 1'b0 ||
                z_resp_rdata !== ((pass == 0) ? 32'h0 : 32'h0BAD_F00D)) begin
                errors++;
                $display("FAIL zw_resp pass%0d: lat=%0d rdata=%h err=%b", pass, cyc,
                         z_resp_rdata, z_resp_err);
            end
            z_resp_ready = 1'b1;
            tick();
            z_resp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; int bad;
        do_req(1'b0, 16'h0010, 32'h0, ok);
        wait_resp(cyc);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 32'hFFFF_0000;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall: %0d bad cycles, vld=%b rdata=%h rdy=%b", bad,
                     resp_valid, resp_rdata, req_ready);
        end
        req_valid = 1'b0;
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        do_req(1'b0, 16'h0010, 32'h0, ok);
        wait_resp(cyc);
        checks++;
        if (!ok || cyc !== 3 || resp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bp_next_req: ok=%0d lat=%0d rdata=%h want 1 3 deadbeef", ok, cyc, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_errors();
        bit ok; int cyc;
        do_req(1'b1, 16'h0012, 32'hBAD0_0012, ok);
        wait_resp(cyc);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0 || cyc !== 3) begin
            errors++;
            $display("FAIL err_misaligned: err=%b rdata=%h lat=%0d want 1 0 3", resp_err, resp_rdata, cyc);
        end
        finish_resp();
        do_req(1'b1, 16'h0400, 32'hBAD0_0400, ok);
        wait_resp(cyc);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_range: err=%b rdata=%h want 1 0", resp_err, resp_rdata);
        end
        finish_resp();
        do_req(1'b0, 16'h0010, 32'h0, ok);
        wait_resp(cyc);
        checks++;
        if (resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write_10: rdata=%h err=%b want deadbeef 0", resp_rdata, resp_err);
        end
        finish_resp();
        do_req(1'b0, 16'h0000, 32'h0, ok);
        wait_resp(cyc);
        checks++;
        if (resp_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL err_no_write_00: rdata=%h want 11111111", resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int cyc;
        do_req(1'b1, 16'h0020, 32'h1234_5678, ok);   // now in WAIT
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: vld=%b rdy=%b want 0 0", resp_valid, req_ready);
        end
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        end
        do_req(1'b0, 16'h0020, 32'h0, ok);
        wait_resp(cyc);
        checks++;
        if (resp_rdata !== 32'hA5A5_A5A5 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_discard: rdata=%h err=%b want a5a5a5a5 0", resp_rdata, resp_err);
        end
        finish_resp();
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
